// File: rtl/count_monitor_4.sv
// count_monitor_4: observes a 2-bit enable-gated wrap-around counter, decodes it,
// pulses carry on legal 3->0 wraps, flags step violations and tallies wraps.
`default_nettype none

module count_monitor_4 #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              r,
    input  logic              en,
    input  logic              q0,
    input  logic              q1,
    input  logic              clr,
    output logic [3:0]        sel,
    output logic              carry,
    output logic              err,
    output logic [WRAP_W-1:0] wraps
);

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  q_prev;
    logic        en_prev;

    logic [1:0]  cur;
    logic [1:0]  exp_q;
    logic        is_wrap;
    logic        wraps_full;

    assign cur        = {q1, q0};
    assign exp_q      = en_prev ? q_prev + 2'd1 : q_prev;
    assign is_wrap    = en_prev && (q_prev == 2'd3);
    assign wraps_full = &wraps;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state   <= PRIME;
            q_prev  <= 2'd0;
            en_prev <= 1'b0;
            sel     <= 4'b0000;
            carry   <= 1'b0;
            err     <= 1'b0;
            wraps   <= '0;
        end else begin
            q_prev  <= cur;
            en_prev <= en;
            sel     <= 4'b0001 << cur;
            carry   <= 1'b0;
            case (state)
                PRIME: begin
                    state <= TRACK;
                    if (clr) begin
                        err   <= 1'b0;
                        wraps <= '0;
                    end
                end
                TRACK: begin
                    if (cur != exp_q) begin
                        // A violation beats a simultaneous clr for err/state.
                        state <= FAULT;
                        err   <= 1'b1;
                        if (clr) begin
                            wraps <= '0;
                        end
                    end else begin
                        if (is_wrap) begin
                            carry <= 1'b1;
                        end
                        if (clr) begin
                            err   <= 1'b0;
                            wraps <= '0;
                        end else if (is_wrap && !wraps_full) begin
                            wraps <= wraps + 1'b1;
                        end
                    end
                end
                FAULT: begin
                    if (clr) begin
                        state <= PRIME;
                        err   <= 1'b0;
                        wraps <= '0;
                    end
                end
                default: begin
                    state <= PRIME;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_count_monitor_4.sv
// Scoreboard bench for count_monitor_4: two instances (8-bit and 2-bit tally) on shared stimulus.
`default_nettype none

module tb_count_monitor_4;

    logic       clk;
    logic       r;
    logic       en;
    logic       q0;
    logic       q1;
    logic       clr;
    logic [3:0] sel_a;
    logic       carry_a;
    logic       err_a;
    logic [7:0] wraps_a;
    logic [3:0] sel_b;
    logic       carry_b;
    logic       err_b;
    logic [1:0] wraps_b;

    count_monitor_4 #(.WRAP_W(8)) dut_a (
        .clk(clk), .r(r), .en(en), .q0(q0), .q1(q1), .clr(clr),
        .sel(sel_a), .carry(carry_a), .err(err_a), .wraps(wraps_a)
    );

    count_monitor_4 #(.WRAP_W(2)) dut_b (
        .clk(clk), .r(r), .en(en), .q0(q0), .q1(q1), .clr(clr),
        .sel(sel_b), .carry(carry_b), .err(err_b), .wraps(wraps_b)
    );

    typedef struct {
        int sel;
        int carry;
        int err;
        int w8;
        int w2;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: what was seen last edge and which phase the monitor is in.
    int m_qprev;
    int m_enprev;
    bit m_need_prime;
    bit m_faulted;
    int m_carries;   // carries since last clear, unsaturated

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_qprev      = 0;
        m_enprev     = 0;
        m_need_prime = 1'b1;
        m_faulted    = 1'b0;
        m_carries    = 0;
    endtask

    // Entered and left at a negedge; the following posedge consumes the inputs.
    task automatic step(input bit e, input int q, input bit c);
        exp_t x;
        int   expect_q;
        en  = e;
        q0  = q[0];
        q1  = q[1];
        clr = c;
        x.carry = 0;
        x.sel   = 1 << q;
        if (m_faulted) begin
            if (c) begin
                m_faulted    = 1'b0;
                m_need_prime = 1'b1;
                m_carries    = 0;
            end
        end else if (m_need_prime) begin
            m_need_prime = 1'b0;
            if (c) m_carries = 0;
        end else begin
            expect_q = m_enprev ? (m_qprev + 1) % 4 : m_qprev;
            if (q != expect_q) begin
                m_faulted = 1'b1;
            end else if (m_enprev == 1 && m_qprev == 3) begin
                x.carry = 1;
                m_carries++;
            end
            if (c) m_carries = 0;
        end
        m_qprev  = q;
        m_enprev = e;
        x.err = m_faulted ? 1 : 0;
        x.w8  = sat(m_carries, 255);
        x.w2  = sat(m_carries, 3);
        sbq.push_back(x);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        r = 1'b0;
        #1;
        chk("rst_sel_a", sel_a, 0);
        chk("rst_carry_a", carry_a, 0);
        chk("rst_err_a", err_a, 0);
        chk("rst_wraps_a", wraps_a, 0);
        chk("rst_sel_b", sel_b, 0);
        chk("rst_wraps_b", wraps_b, 0);
        @(negedge clk);
        r = 1'b1;
        model_reset();
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk("sel_a", sel_a, x.sel);
            chk("carry_a", carry_a, x.carry);
            chk("err_a", err_a, x.err);
            chk("wraps_a", wraps_a, x.w8);
            chk("sel_b", sel_b, x.sel);
            chk("carry_b", carry_b, x.carry);
            chk("err_b", err_b, x.err);
            chk("wraps_b", wraps_b, x.w2);
        end
    end

    initial begin
        int cq;
        bit e;
        int q;
        r   = 1'b1;
        en  = 1'b0;
        q0  = 1'b0;
        q1  = 1'b0;
        clr = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset and prime with q=2, en=0
        q1 = 1'b1;
        apply_reset();
        step(1'b0, 2, 1'b0);

        // Full count, continuing to five wraps (saturates the 2-bit tally)
        apply_reset();
        for (int i = 0; i < 24; i++) step(1'b1, i % 4, 1'b0);

        // clr coinciding with a carry
        step(1'b1, 0, 1'b1);
        step(1'b1, 1, 1'b0);

        // Hold, then an illegal jump while disabled
        for (int i = 0; i < 6; i++) step(1'b0, 2, 1'b0);
        step(1'b0, 3, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, i % 4, 1'b0);

        // Recovery: clr, prime edge, then clean checking
        step(1'b0, 1, 1'b1);
        step(1'b0, 1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, (1 + i) % 4, 1'b0);

        // Violation together with clr in TRACK
        step(1'b0, 3, 1'b0);
        step(1'b1, 1, 1'b1);
        step(1'b0, 1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, (1 + i) % 4, 1'b0);

        // Asynchronous reset mid-count
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b1, i % 4, 1'b0);

        // Randomized counter traffic with occasional glitches, clears and resets
        cq = 0;
        for (int n = 0; n < 3000; n++) begin
            e = ($urandom % 4) != 0;
            q = (($urandom % 40) == 0) ? int'($urandom % 4) : cq;
            step(e, q, ($urandom % 25) == 0);
            cq = e ? (cq + 1) % 4 : cq;
            if (($urandom % 600) == 0) apply_reset();
        end

        @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
